keypad_calc_entry: RTL and testbench

- Consumer end of the keypad scanner interface.
- Takes the registered 4-bit key code and key-pressed level from the scanner and detects individual key presses.
- Assembles two BCD operands and an operator.
- Hands the operation to the arithmetic unit over a valid/ready handshake, and drives the operand being typed to the display path.

---
 rtl/keypad_calc_entry.sv | 171 +++++++++++++++++
 tb/tb_keypad_calc_entry.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/keypad_calc_entry.sv
// Keypad entry front end: turns scanner key presses into two BCD operands plus an operator for the arithmetic unit.
// Optional backspace on key 0xE is built when KEYPAD_CALC_BACKSPACE_EN is defined.
`timescale 1ns/1ps
module keypad_calc_entry #(
   parameter int N_DIGITS = 3
) (
   input  logic                  clk_10m,
   input  logic                  reset,
   input  logic [3:0]            key_code,
   input  logic                  key_valid,
   output logic                  op_valid,
   input  logic                  op_ready,
   output logic [4*N_DIGITS-1:0] op_a,
   output logic [4*N_DIGITS-1:0] op_b,
   output logic [1:0]            op_code,
   output logic [4*N_DIGITS-1:0] disp_bcd,
   output logic [1:0]            entry_state
);

   localparam int W  = 4 * N_DIGITS;
   localparam int CW = $clog2(N_DIGITS + 1);

   typedef enum logic [1:0] {
      ENTER_A  = 2'b00,
      ENTER_B  = 2'b01,
      WAIT_ACK = 2'b10,
      DONE     = 2'b11
   } state_t;

   state_t          state_reg, state_next;
   logic [W-1:0]    a_reg, a_next;
   logic [W-1:0]    b_reg, b_next;
   logic [1:0]      code_reg, code_next;
   logic [CW-1:0]   cnt_a_reg, cnt_a_next;
   logic [CW-1:0]   cnt_b_reg, cnt_b_next;
   logic            kv_d_reg;

   logic key_evt, is_digit, is_op;

   assign key_evt  = key_valid & ~kv_d_reg;
   assign is_digit = (key_code <= 4'd9);
   assign is_op    = (key_code == 4'hA) || (key_code == 4'hB) || (key_code == 4'hC);

   // A digit is taken unless it is a leading zero or the operand is already full.
   function automatic logic digit_ok(input logic [CW-1:0] cnt, input logic [3:0] d);
      return !(cnt == '0 && d == 4'd0) && (cnt != CW'(N_DIGITS));
   endfunction

   function automatic logic [W-1:0] shift_in(input logic [W-1:0] v, input logic [3:0] d);
      logic [W+3:0] t;
      t = {v, d};
      return t[W-1:0];
   endfunction

   function automatic logic [1:0] op_of(input logic [3:0] k);
      case (k)
         4'hB:    return 2'b01;
         4'hC:    return 2'b10;
         default: return 2'b00;
      endcase
   endfunction

   always_comb begin
      state_next = state_reg;
      a_next     = a_reg;
      b_next     = b_reg;
      code_next  = code_reg;
      cnt_a_next = cnt_a_reg;
      cnt_b_next = cnt_b_reg;

      if (state_reg == WAIT_ACK && op_ready)
         state_next = DONE;

      if (key_evt) begin
         if (key_code == 4'hF) begin
            // Clear overrides everything, including a handshake in the same cycle.
            state_next = ENTER_A;
            a_next     = '0;
            b_next     = '0;
            code_next  = 2'b00;
            cnt_a_next = '0;
            cnt_b_next = '0;
         end else begin
            case (state_reg)
               ENTER_A: begin
                  if (is_digit) begin
                     if (digit_ok(cnt_a_reg, key_code)) begin
                        a_next     = shift_in(a_reg, key_code);
                        cnt_a_next = cnt_a_reg + CW'(1);
                     end
                  end else if (is_op) begin
                     code_next  = op_of(key_code);
                     b_next     = '0;
                     cnt_b_next = '0;
                     state_next = ENTER_B;
                  end
`ifdef KEYPAD_CALC_BACKSPACE_EN
                  else if (key_code == 4'hE && cnt_a_reg != '0) begin
                     a_next     = a_reg >> 4;
                     cnt_a_next = cnt_a_reg - CW'(1);
                  end
`endif
               end
               ENTER_B: begin
                  if (is_digit) begin
                     if (digit_ok(cnt_b_reg, key_code)) begin
                        b_next     = shift_in(b_reg, key_code);
                        cnt_b_next = cnt_b_reg + CW'(1);
                     end
                  end else if (is_op) begin
                     if (cnt_b_reg == '0)
                        code_next = op_of(key_code);
                  end else if (key_code == 4'hD) begin
                     state_next = WAIT_ACK;
                  end
`ifdef KEYPAD_CALC_BACKSPACE_EN
                  else if (key_code == 4'hE && cnt_b_reg != '0) begin
                     b_next     = b_reg >> 4;
                     cnt_b_next = cnt_b_reg - CW'(1);
                  end
`endif
               end
               DONE: begin
                  if (is_digit) begin
                     // New calculation: the digit becomes the first digit of a fresh A.
                     a_next     = (key_code == 4'd0) ? '0 : W'(key_code);
                     cnt_a_next = (key_code == 4'd0) ? '0 : CW'(1);
                     b_next     = '0;
                     cnt_b_next = '0;
                     state_next = ENTER_A;
                  end else if (is_op) begin
                     code_next  = op_of(key_code);
                     b_next     = '0;
                     cnt_b_next = '0;
                     state_next = ENTER_B;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk_10m or negedge reset) begin
      if (!reset) begin
         state_reg <= ENTER_A;
         a_reg     <= '0;
         b_reg     <= '0;
         code_reg  <= 2'b00;
         cnt_a_reg <= '0;
         cnt_b_reg <= '0;
         kv_d_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         a_reg     <= a_next;
         b_reg     <= b_next;
         code_reg  <= code_next;
         cnt_a_reg <= cnt_a_next;
         cnt_b_reg <= cnt_b_next;
         kv_d_reg  <= key_valid;
      end
   end

   assign op_valid    = (state_reg == WAIT_ACK);
   assign op_a        = a_reg;
   assign op_b        = b_reg;
   assign op_code     = code_reg;
   assign entry_state = state_reg;
   assign disp_bcd    = (state_reg == ENTER_A) ? a_reg : b_reg;

endmodule

// File: tb/tb_keypad_calc_entry.sv
// Bench for keypad_calc_entry: key-sequence vector table, scoreboard of issued operations, hand-written corner cases.
`timescale 1ns/1ps
module tb_keypad_calc_entry;

   logic        clk_10m = 1'b0;
   logic        reset;
   logic [3:0]  key_code;
   logic        key_valid;
   logic        op_valid;
   logic        op_ready;
   logic [11:0] op_a, op_b, disp_bcd;
   logic [1:0]  op_code, entry_state;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic [31:0] keys;
      int          nkeys;
      logic [11:0] a;
      logic [11:0] b;
      logic [1:0]  code;
      logic [1:0]  st;
   } vec_t;

   typedef struct {
      logic [11:0] a;
      logic [11:0] b;
      logic [1:0]  code;
   } op_t;

   vec_t vecs[8];
   op_t  sb_q[$];

   keypad_calc_entry #(.N_DIGITS(3)) dut (
      .clk_10m     (clk_10m),
      .reset       (reset),
      .key_code    (key_code),
      .key_valid   (key_valid),
      .op_valid    (op_valid),
      .op_ready    (op_ready),
      .op_a        (op_a),
      .op_b        (op_b),
      .op_code     (op_code),
      .disp_bcd    (disp_bcd),
      .entry_state (entry_state)
   );

   always #50 clk_10m = ~clk_10m;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic press(input logic [3:0] k);
      @(negedge clk_10m);
      key_code  = k;
      key_valid = 1'b1;
      repeat (2) @(negedge clk_10m);
      key_valid = 1'b0;
      repeat (2) @(negedge clk_10m);
      $display("key %h -> a=%h b=%h code=%0d st=%0d valid=%0b", k, op_a, op_b, op_code, entry_state, op_valid);
   endtask

   task automatic check_all(input string tag, input logic [11:0] a, input logic [11:0] b,
                            input logic [1:0] code, input logic [1:0] st);
      chk({tag, "_a"}, op_a, a);
      chk({tag, "_b"}, op_b, b);
      chk({tag, "_code"}, op_code, code);
      chk({tag, "_st"}, entry_state, st);
      chk({tag, "_valid"}, op_valid, (st == 2'd2));
      chk({tag, "_disp"}, disp_bcd, (st == 2'd0) ? a : b);
   endtask

   // One-cycle op_ready pulse; the accepted operation is checked against the scoreboard.
   task automatic handshake(input string tag);
      op_t e;
      op_ready = 1'b1;
      chk({tag, "_hs_valid"}, op_valid, 1'b1);
      if (sb_q.size() == 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s_sb_empty: got operation a=%h expected none", tag, op_a);
      end else begin
         e = sb_q.pop_front();
         chk({tag, "_hs_a"}, op_a, e.a);
         chk({tag, "_hs_b"}, op_b, e.b);
         chk({tag, "_hs_code"}, op_code, e.code);
      end
      @(negedge clk_10m);
      op_ready = 1'b0;
      chk({tag, "_post_valid"}, op_valid, 1'b0);
      chk({tag, "_post_st"}, entry_state, 2'd3);
      $display("handshake %s -> st=%0d valid=%0b", tag, entry_state, op_valid);
   endtask

   initial begin
      vecs[0] = '{32'h12A3D000, 5, 12'h012, 12'h003, 2'd0, 2'd2};
      vecs[1] = '{32'h00987600, 6, 12'h987, 12'h000, 2'd0, 2'd0};
      vecs[2] = '{32'h5ABC4BD0, 7, 12'h005, 12'h004, 2'd2, 2'd2};
`ifdef KEYPAD_CALC_BACKSPACE_EN
      vecs[3] = '{32'h456EE700, 6, 12'h047, 12'h000, 2'd0, 2'd0};
`else
      vecs[3] = '{32'h456EE700, 6, 12'h456, 12'h000, 2'd0, 2'd0};
`endif
      vecs[4] = '{32'h3D000000, 2, 12'h003, 12'h000, 2'd0, 2'd0};
      vecs[5] = '{32'h2BD00000, 3, 12'h002, 12'h000, 2'd1, 2'd2};
      vecs[6] = '{32'h1A2C0000, 4, 12'h001, 12'h002, 2'd0, 2'd1};
      vecs[7] = '{32'h0A070000, 4, 12'h000, 12'h007, 2'd0, 2'd1};

      reset     = 1'b0;
      key_code  = 4'h0;
      key_valid = 1'b0;
      op_ready  = 1'b0;
      repeat (3) @(negedge clk_10m);
      reset = 1'b1;
      @(negedge clk_10m);
      check_all("reset", 12'h000, 12'h000, 2'd0, 2'd0);

      // Basic operation held in WAIT_ACK, then accepted, then a digit starts over.
      press(4'h1); press(4'h2); press(4'hA); press(4'h3); press(4'hD);
      check_all("seq1", 12'h012, 12'h003, 2'd0, 2'd2);
      sb_q.push_back('{12'h012, 12'h003, 2'd0});
      repeat (20) @(negedge clk_10m);
      chk("seq1_hold_st", entry_state, 2'd2);
      chk("seq1_hold_valid", op_valid, 1'b1);
      handshake("seq1");
      press(4'h7);
      check_all("seq1_new", 12'h007, 12'h000, 2'd0, 2'd0);

      for (int i = 0; i < 8; i++) begin
         press(4'hF);
         for (int k = 0; k < vecs[i].nkeys; k++)
            press(vecs[i].keys[31-4*k -: 4]);
         check_all($sformatf("v%0d", i), vecs[i].a, vecs[i].b, vecs[i].code, vecs[i].st);
         if (vecs[i].st == 2'd2) begin
            sb_q.push_back('{vecs[i].a, vecs[i].b, vecs[i].code});
            handshake($sformatf("v%0d", i));
         end
      end

      // One long hold must give exactly one digit.
      press(4'hF);
      @(negedge clk_10m);
      key_code  = 4'h1;
      key_valid = 1'b1;
      repeat (50) @(negedge clk_10m);
      key_valid = 1'b0;
      repeat (2) @(negedge clk_10m);
      chk("hold_a", op_a, 12'h001);
      press(4'h2);
      chk("hold_a2", op_a, 12'h012);

      // op_ready without op_valid changes nothing.
      op_ready = 1'b1;
      repeat (3) @(negedge clk_10m);
      op_ready = 1'b0;
      chk("idle_ready_st", entry_state, 2'd0);
      chk("idle_ready_a", op_a, 12'h012);

      // Clear in the same cycle as a handshake wins.
      press(4'hF); press(4'h1); press(4'hA); press(4'h2); press(4'hD);
      chk("clrhs_pre_valid", op_valid, 1'b1);
      key_code  = 4'hF;
      key_valid = 1'b1;
      op_ready  = 1'b1;
      @(negedge clk_10m);
      op_ready = 1'b0;
      check_all("clrhs", 12'h000, 12'h000, 2'd0, 2'd0);
      key_valid = 1'b0;
      repeat (2) @(negedge clk_10m);
      $display("clear+handshake -> st=%0d valid=%0b", entry_state, op_valid);

      // Operator in DONE chains on the previous A.
      press(4'h6); press(4'hA); press(4'h3); press(4'hD);
      sb_q.push_back('{12'h006, 12'h003, 2'd0});
      handshake("chain");
      press(4'hB);
      check_all("chain", 12'h006, 12'h000, 2'd1, 2'd1);

      // Asynchronous reset mid-ENTER_B, checked before any clock edge.
      press(4'hF); press(4'h1); press(4'hA); press(4'h2);
      chk("arst_pre_b", op_b, 12'h002);
      chk("arst_pre_st", entry_state, 2'd1);
      #10;
      reset = 1'b0;
      #5;
      check_all("arst", 12'h000, 12'h000, 2'd0, 2'd0);
      @(negedge clk_10m);
      reset = 1'b1;
      @(negedge clk_10m);
      $display("async reset -> a=%h b=%h st=%0d", op_a, op_b, entry_state);

      chk("sb_drained", sb_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
